// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer wrapped around a purely combinational 8-bit alu.
// Optional macro ALU_CARRY_CHAIN_EN adds in_use_carry and an internal carry_flag for multi-word chains.
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_valid/res_ready are sampled only in IDLE/DONE respectively and ignored elsewhere.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_sel,
`ifdef ALU_CARRY_CHAIN_EN
    input  logic             in_use_carry,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_cout,
    output logic [CNT_W-1:0] op_count,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

`ifdef ALU_CARRY_CHAIN_EN
    logic carry_flag;
    logic next_cin;
    assign next_cin = in_use_carry ? carry_flag : in_cin;
`else
    logic next_cin;
    assign next_cin = in_cin;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_sel   <= 2'b00;
            res_out   <= '0;
            res_cout  <= 1'b0;
            op_count  <= '0;
`ifdef ALU_CARRY_CHAIN_EN
            carry_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        alu_cin  <= next_cin;
                        alu_sel  <= in_sel;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // The alu has had a full cycle to settle on the registered operands.
                    res_out   <= alu_out;
                    res_cout  <= alu_cout;
`ifdef ALU_CARRY_CHAIN_EN
                    carry_flag <= alu_cout;
`endif
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu stand-in on the alu_* ports.
// Build with ALU_CARRY_CHAIN_EN defined to cover the carry-chain option as well.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic [1:0] in_sel;
    logic       in_use_carry;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_out;
    logic       res_cout;
    logic [7:0] op_count;
    logic       busy;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_count = 8'd0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_cin(in_cin),
        .in_sel(in_sel),
`ifdef ALU_CARRY_CHAIN_EN
        .in_use_carry(in_use_carry),
`endif
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_cin(alu_cin),
        .alu_sel(alu_sel),
        .alu_out(alu_out),
        .alu_cout(alu_cout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_out(res_out),
        .res_cout(res_cout),
        .op_count(op_count),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    // Stand-in alu: 00 add with carry, 01 and, 10 or, 11 xor.
    always_comb begin
        alu_out  = 8'h00;
        alu_cout = 1'b0;
        case (alu_sel)
            2'b00:   {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            2'b01:   alu_out = alu_a & alu_b;
            2'b10:   alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation for a single accept edge; leaves the DUT in EXEC.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [1:0] sel, input logic uc, input logic [8:0] exp_res);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sel = sel;
        in_use_carry = uc;
        exp_q.push_back(exp_res);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for the result, checks it against the queue head, then consumes it.
    task automatic collect(input string tag);
        logic [8:0] exp_res;
        int n;
        n = 0;
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        check({tag, "_res_out"}, {24'd0, res_out}, {24'd0, exp_res[7:0]});
        check({tag, "_res_cout"}, {31'd0, res_cout}, {31'd0, exp_res[8]});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        check({tag, "_op_count"}, {24'd0, op_count}, {24'd0, exp_count});
        check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_cin = 1'b0;
        in_sel = 2'b00;
        in_use_carry = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_res_out", {24'd0, res_out}, 32'd0);
        rst = 1'b0;

        // 1: 01+08 -> 09, result valid exactly two edges after presenting
        issue(8'h01, 8'h08, 1'b0, 2'b00, 1'b0, 9'h009);
        check("t1_busy_exec", {31'd0, busy}, 32'd1);
        check("t1_in_ready_exec", {31'd0, in_ready}, 32'd0);
        check("t1_res_valid_early", {31'd0, res_valid}, 32'd0);
        check("t1_alu_b", {24'd0, alu_b}, 32'h08);
        @(negedge clk);
        check("t1_res_valid_2edges", {31'd0, res_valid}, 32'd1);
        collect("t1");

        // 2: 81+80+1 -> carry out, 02
        issue(8'h81, 8'h80, 1'b1, 2'b00, 1'b0, 9'h102);
        check("t2_alu_cin", {31'd0, alu_cin}, 32'd1);
        collect("t2");

        // 3: back-pressure in DONE, new requests ignored
        issue(8'h10, 8'h20, 1'b0, 2'b11, 1'b0, 9'h030);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_a = 8'hA0 + 8'(i);
            @(negedge clk);
            check("t3_in_ready_hold", {31'd0, in_ready}, 32'd0);
            check("t3_res_valid_hold", {31'd0, res_valid}, 32'd1);
            check("t3_res_out_hold", {24'd0, res_out}, 32'h30);
            check("t3_alu_a_hold", {24'd0, alu_a}, 32'h10);
        end
        in_valid = 1'b0;
        collect("t3");
        @(negedge clk);
        check("t3_no_accept", {31'd0, busy}, 32'd0);

        // 4: asynchronous reset while in EXEC
        issue(8'h55, 8'h22, 1'b0, 2'b00, 1'b0, 9'h077);
        check("t4_in_exec", {30'd0, fsm_state}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t4_in_ready_async", {31'd0, in_ready}, 32'd1);
        check("t4_busy_async", {31'd0, busy}, 32'd0);
        check("t4_res_valid_async", {31'd0, res_valid}, 32'd0);
        check("t4_op_count_async", {24'd0, op_count}, 32'd0);
        check("t4_alu_a_async", {24'd0, alu_a}, 32'd0);
        void'(exp_q.pop_back());
        exp_count = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_still_idle", {31'd0, res_valid}, 32'd0);

        // 5: op_count wrap after 256 completed operations
        for (int i = 0; i < 255; i++) begin
            issue(8'(i), 8'h01, 1'b0, 2'b00, 1'b0, {1'b0, 8'(i)} + 9'd1);
            collect("t5_fill");
        end
        check("t5_count_255", {24'd0, op_count}, 32'd255);
        issue(8'hF0, 8'h0F, 1'b0, 2'b10, 1'b0, 9'h0FF);
        collect("t5_wrap");
        check("t5_count_0", {24'd0, op_count}, 32'd0);

`ifdef ALU_CARRY_CHAIN_EN
        // 6: carry chain through carry_flag
        issue(8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 9'h100);
        collect("t6_low");
        issue(8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 9'h001);
        check("t6_alu_cin_chain", {31'd0, alu_cin}, 32'd1);
        collect("t6_high");
`else
        // Without the chain option, alu_cin always follows in_cin.
        issue(8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 9'h100);
        collect("t6_low");
        issue(8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 9'h000);
        check("t6_alu_cin_plain", {31'd0, alu_cin}, 32'd0);
        collect("t6_high");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
